// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared constants and types for the ARM register file
//
// Purpose: default PC location and step, plus the 4-bit register address
//          type used by the classic 16-entry datapath.
// Ports:   none (package).
package arm_pkg;

   localparam int PC_INDEX = 15;
   localparam int PC_STEP  = 4;

   typedef logic [3:0] reg_addr_t;

endpackage : arm_pkg

// File: rtl/arm_regfile_read_port.sv
// rtl/arm_regfile_read_port.sv - one combinational read port of the register file
//
// Purpose: selects one register from the bank, returns 0 for addresses past
//          the end of the bank, and optionally forwards same-cycle write data.
// Ports:
//   addr_i     - read address
//   regs_i     - current stored register values
//   wr_en_i    - qualified write strobe (already gated by reset and range)
//   wr_addr_i  - write address
//   wr_data_i  - write data
//   data_o     - read data
module arm_regfile_read_port
   import arm_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NREGS  = 16,
   parameter int BYPASS = 1,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic [AW-1:0]    addr_i,
   input  logic [WIDTH-1:0] regs_i [NREGS],
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic [WIDTH-1:0] data_o
);

   logic in_range;
   logic bypass_hit;

   // Addresses past the end of the bank exist only when NREGS is not a
   // power of two.
   assign in_range = (int'(addr_i) < NREGS);

   // wr_en_i is only high for in-range writes, so a hit implies the read
   // address is in range as well.
   assign bypass_hit = (BYPASS != 0) && wr_en_i && (wr_addr_i == addr_i);

   always_comb begin
      data_o = '0;
      if (in_range) begin
         if (bypass_hit) begin
            data_o = wr_data_i;
         end else begin
            data_o = regs_i[addr_i];
         end
      end
   end

endmodule : arm_regfile_read_port

// File: rtl/arm_regfile.sv
// rtl/arm_regfile.sv - parametrised register bank with auto-incrementing PC
//
// Purpose: NREGS x WIDTH flip-flop register bank, two combinational read
//          ports, one synchronous write port; the top register is the PC.
// Ports:
//   CLK    - clock, all state updates on rising edge
//   RESET  - synchronous active-high reset, clears every register
//   A, B   - read addresses for ports A and B
//   C      - write address
//   DIN    - write data
//   ENABLE - write enable
//   PCINC  - advance the PC by PC_STEP
//   PA, PB - read data for ports A and B
//   PCOUT  - stored PC value (never bypassed)
module arm_regfile
   import arm_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NREGS   = 16,
   parameter int AW      = $clog2(NREGS),
   parameter int PC_STEP = arm_pkg::PC_STEP,
   parameter int BYPASS  = 1
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [AW-1:0]    A,
   input  logic [AW-1:0]    B,
   input  logic [AW-1:0]    C,
   input  logic [WIDTH-1:0] DIN,
   input  logic             ENABLE,
   input  logic             PCINC,
   output logic [WIDTH-1:0] PA,
   output logic [WIDTH-1:0] PB,
   output logic [WIDTH-1:0] PCOUT
);

   localparam int          PC      = NREGS - 1;
   localparam logic [AW-1:0] PC_ADDR = AW'(NREGS - 1);

   logic [WIDTH-1:0] r_q [NREGS];
   logic [WIDTH-1:0] r_d [NREGS];

   logic wr_valid;
   logic wr_pc;

   // A write only counts when it targets a real register and reset is low;
   // the same strobe drives bypass so a dropped write is never forwarded.
   assign wr_valid = ENABLE && !RESET && (int'(C) < NREGS);
   assign wr_pc    = wr_valid && (C == PC_ADDR);

   always_comb begin
      r_d = r_q;
      if (wr_valid) begin
         r_d[C] = DIN;
      end
      // An explicit PC write beats the increment; a write elsewhere does not.
      if (PCINC && !wr_pc) begin
         r_d[PC] = r_q[PC] + WIDTH'(PC_STEP);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NREGS; i++) begin
            r_q[i] <= '0;
         end
      end else begin
         r_q <= r_d;
      end
   end

   arm_regfile_read_port #(
      .WIDTH  (WIDTH),
      .NREGS  (NREGS),
      .BYPASS (BYPASS),
      .AW     (AW)
   ) u_port_a (
      .addr_i    (A),
      .regs_i    (r_q),
      .wr_en_i   (wr_valid),
      .wr_addr_i (C),
      .wr_data_i (DIN),
      .data_o    (PA)
   );

   arm_regfile_read_port #(
      .WIDTH  (WIDTH),
      .NREGS  (NREGS),
      .BYPASS (BYPASS),
      .AW     (AW)
   ) u_port_b (
      .addr_i    (B),
      .regs_i    (r_q),
      .wr_en_i   (wr_valid),
      .wr_addr_i (C),
      .wr_data_i (DIN),
      .data_o    (PB)
   );

   assign PCOUT = r_q[PC];

endmodule : arm_regfile

// File: tb/tb_arm_regfile.sv
// tb/tb_arm_regfile.sv - directed table-driven bench for arm_regfile
module tb_arm_regfile;

   logic        clk;
   logic        reset;
   logic [3:0]  a, b, c;
   logic [31:0] din;
   logic        enable;
   logic        pcinc;

   logic [31:0] pa, pb, pcout;
   logic [31:0] pa_nb, pb_nb, pcout_nb;
   logic [31:0] pa12, pb12, pcout12;

   int tests  = 0;
   int failed = 0;

   arm_regfile dut (
      .CLK(clk), .RESET(reset), .A(a), .B(b), .C(c), .DIN(din),
      .ENABLE(enable), .PCINC(pcinc), .PA(pa), .PB(pb), .PCOUT(pcout)
   );

   arm_regfile #(.BYPASS(0)) dut_nb (
      .CLK(clk), .RESET(reset), .A(a), .B(b), .C(c), .DIN(din),
      .ENABLE(enable), .PCINC(pcinc), .PA(pa_nb), .PB(pb_nb), .PCOUT(pcout_nb)
   );

   arm_regfile #(.NREGS(12)) dut12 (
      .CLK(clk), .RESET(reset), .A(a), .B(b), .C(c), .DIN(din),
      .ENABLE(enable), .PCINC(pcinc), .PA(pa12), .PB(pb12), .PCOUT(pcout12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        en;
      logic        inc;
      logic [3:0]  a;
      logic [3:0]  b;
      logic [3:0]  c;
      logic [31:0] din;
      logic [31:0] exp_pa;
      logic [31:0] exp_pb;
      logic [31:0] exp_pc;
      logic [31:0] exp_pa_nb;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic en, input logic inc,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rc, input logic [31:0] d);
      reset  = rst;
      enable = en;
      pcinc  = inc;
      a      = ra;
      b      = rb;
      c      = rc;
      din    = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          rst en inc a   b   c   din            pa             pb             pcout          pa_nb
      vecs[0]  = '{0, 1, 0, 0,  1,  3,  32'hDEAD_BEEF, 32'h0,         32'h0,         32'h0,         32'h0};
      vecs[1]  = '{0, 0, 0, 3,  3,  0,  32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF};
      vecs[2]  = '{1, 1, 1, 3,  4,  3,  32'h1111_1111, 32'hDEAD_BEEF, 32'h0,         32'h0,         32'hDEAD_BEEF};
      vecs[3]  = '{0, 0, 0, 3,  15, 0,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0};
      vecs[4]  = '{0, 1, 0, 0,  0,  5,  32'h1234_5678, 32'h0,         32'h0,         32'h0,         32'h0};
      vecs[5]  = '{0, 0, 0, 5,  5,  0,  32'h0,         32'h1234_5678, 32'h1234_5678, 32'h0,         32'h1234_5678};
      vecs[6]  = '{0, 1, 0, 6,  5,  6,  32'h6666_6666, 32'h6666_6666, 32'h1234_5678, 32'h0,         32'h0};
      vecs[7]  = '{0, 1, 0, 7,  6,  7,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h6666_6666, 32'h0,         32'h0};
      vecs[8]  = '{0, 0, 0, 7,  7,  0,  32'h0,         32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0,         32'hA5A5_A5A5};
      vecs[9]  = '{0, 1, 0, 15, 0,  15, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h0,         32'h0};
      vecs[10] = '{0, 0, 1, 15, 14, 0,  32'h0,         32'hFFFF_FFFC, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC};
      vecs[11] = '{0, 0, 1, 15, 14, 0,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0};
      vecs[12] = '{0, 0, 0, 15, 14, 0,  32'h0,         32'h4,         32'h0,         32'h4,         32'h4};
      vecs[13] = '{0, 1, 1, 15, 0,  15, 32'h100,       32'h100,       32'h0,         32'h4,         32'h4};
      vecs[14] = '{0, 1, 1, 2,  15, 2,  32'h2222_2222, 32'h2222_2222, 32'h100,       32'h100,       32'h0};
      vecs[15] = '{0, 0, 0, 2,  15, 0,  32'h0,         32'h2222_2222, 32'h104,       32'h104,       32'h2222_2222};

      drive(1, 0, 0, 0, 0, 0, 32'h0);
      step();

      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].inc, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].din);
         #2;
         check($sformatf("v%0d pa", i), pa, vecs[i].exp_pa);
         check($sformatf("v%0d pb", i), pb, vecs[i].exp_pb);
         check($sformatf("v%0d pcout", i), pcout, vecs[i].exp_pc);
         check($sformatf("v%0d pa_nobypass", i), pa_nb, vecs[i].exp_pa_nb);
         check($sformatf("v%0d pcout_nobypass", i), pcout_nb, vecs[i].exp_pc);
         step();
      end

      // Port B of the no-bypass bank sees the incremented PC after the table.
      drive(0, 0, 0, 2, 15, 0, 32'h0);
      #2;
      check("nb pb pc", pb_nb, 32'h104);
      check("nb pa r2", pa_nb, 32'h2222_2222);

      // Twelve-register bank: R11 is the PC, addresses 12..15 are holes.
      drive(1, 0, 0, 0, 0, 0, 32'h0);
      step();
      drive(0, 1, 0, 0, 0, 3, 32'h0000_0033);
      step();
      drive(0, 1, 0, 13, 3, 13, 32'hDEAD_BEEF);
      #2;
      check("n12 oor bypass", pa12, 32'h0);
      check("n12 pb r3", pb12, 32'h0000_0033);
      step();
      for (int r = 0; r < 12; r++) begin
         drive(0, 0, 0, 4'(r), 4'(r), 0, 32'h0);
         #2;
         check($sformatf("n12 r%0d", r), pa12, (r == 3) ? 32'h0000_0033 : 32'h0);
      end
      drive(0, 0, 0, 14, 13, 0, 32'h0);
      #2;
      check("n12 read a14", pa12, 32'h0);
      check("n12 read b13", pb12, 32'h0);
      drive(0, 0, 1, 11, 0, 0, 32'h0);
      step();
      drive(0, 0, 0, 11, 0, 0, 32'h0);
      #2;
      check("n12 pcout", pcout12, 32'h4);
      check("n12 pa pc", pa12, 32'h4);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule : tb_arm_regfile

// File: doc/arm_regfile.md
# arm_regfile

Parametrised successor to the 16×32 register file of the ARM datapath. It provides a configurable-width, configurable-depth bank with two combinational read ports and one synchronous write port. Optional write-to-read bypass is included. The top register is a program counter that auto-increments under `PCINC`. The block sits between instruction decode (register addresses) and the ALU/shifter operand buses, and replaces the latch-based bank with edge-triggered storage and synchronous reset.

## Interface
Parameters:
- `WIDTH`, 32, data width of every register.
- `NREGS`, 16, register count, ≥2; register `NREGS-1` is the PC.
- `AW`, `$clog2(NREGS)`, address width.
- `PC_STEP`, 4, PC increment per `PCINC` cycle.
- `BYPASS`, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see stored value only.

Ports:
- `CLK` in 1: single clock; all state updates on rising edge.
- `RESET` in 1: synchronous, active-high.
- `A` in AW: read address, port A.
- `B` in AW: read address, port B.
- `C` in AW: write address.
- `DIN` in WIDTH: write data.
- `ENABLE` in 1: write enable.
- `PCINC` in 1: advance PC by `PC_STEP`.
- `PA` out WIDTH: read data, port A.
- `PB` out WIDTH: read data, port B.
- `PCOUT` out WIDTH: current PC (`R[NREGS-1]`), registered value, never bypassed.

## Operation
- Storage is `R[0..NREGS-1]`, each WIDTH-bit, flip-flop based.
- Reset: `RESET`=1 at a rising edge sets every register to 0. `ENABLE` and `PCINC` are ignored that cycle. The cycle after reset, `PA`=`PB`=`PCOUT`=0.
- Write: with `ENABLE`=1 and `RESET`=0, `R[C]` ← `DIN` at the edge.
- PC update priority at the edge, for `R[NREGS-1]`: `RESET` > explicit write (`ENABLE` and `C`=`NREGS-1`) > `PCINC` (R ← R+`PC_STEP`, modulo 2^WIDTH, carry discarded) > hold.
- `PCINC` with `ENABLE` to a non-PC register: both take effect in the same cycle.
- Read: `PA` = `R[A]`, `PB` = `R[B]`, combinational.
- Bypass (`BYPASS`=1): if `ENABLE`=1, `RESET`=0 and `C`=`A`, then `PA`=`DIN`. `PB` behaves the same with `C`=`B`. Bypass is suppressed while `RESET`=1.
- Bypass does not forward the PC increment: reading `NREGS-1` during `PCINC` returns the pre-increment value.
- Out-of-range address (`A`, `B` or `C` ≥ `NREGS`, possible only when `NREGS` is not a power of two):
  - reads return 0;
  - writes are ignored, and bypass does not fire.
- `A`=`B` is legal; both ports return identical data.

## Timing
- Read latency: 0 cycles (combinational from `A`, `B`, `R`, and `DIN`/`C`/`ENABLE` when `BYPASS`=1).
- Write latency: 1 edge. Data is visible through storage from the cycle after the write edge, and visible in the same cycle via bypass.
- PC increment: 1 edge. `PCOUT` shows the new value after the edge.
- Reset mid-operation: a write or increment presented in the reset cycle is lost. Normal operation resumes on the first edge with `RESET`=0.
- No handshake. The block accepts a write every cycle.

## Structure
- Shared package `arm_pkg` holds:
  - `PC_INDEX` default (15);
  - `PC_STEP` default (4);
  - a `reg_addr_t` typedef for 4-bit addresses.
- Sub-module `arm_regfile_read_port`: one instance per read port. It contains the address mux, range check and bypass compare, and is parametrised by `WIDTH`, `NREGS` and `BYPASS`.
- Storage and PC update logic live in the top module.

## Test plan
- Reset: preload `R3`=`32'hDEAD_BEEF`, assert `RESET` for 1 cycle → `PA`(A=3)=0, `PCOUT`=0.
- Write/read: write `R5`=`32'h1234_5678`, next cycle A=5, B=5 → `PA`=`PB`=`32'h1234_5678`.
- Bypass: `ENABLE`=1, C=7, `DIN`=`32'hA5A5_A5A5`, A=7, B=6 in the same cycle → `PA`=`32'hA5A5_A5A5`, `PB`=old `R6`. With `BYPASS`=0 → `PA`=old `R7`.
- PC increment and wrap: write `R15`=`32'hFFFF_FFFC`, then `PCINC`=1 for 2 cycles → `PCOUT`=0, then 4.
- PC priority: `PCINC`=1 with `ENABLE`=1, C=15, `DIN`=`32'h100` → `PCOUT`=`32'h100` (not +4). Same cycle with C=2 → `R2` written and PC incremented.
- Out of range (`NREGS`=12): write C=13 → no register changes; A=14 → `PA`=0.
